// File: rtl/ad936x_spi_ctrl.sv
// AD936x SPI register controller: chip reset sequencing, 24-bit single-byte
// frames, read-back. Ports: clock/nreset, cmd_* in, rsp_*/busy out, chip pins.
module ad936x_spi_ctrl #(
  parameter int unsigned CLK_DIV    = 4,
  parameter int unsigned RST_CYCLES = 1024
) (
  input  logic       clock,
  input  logic       nreset,
  input  logic       reset_req,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_write,
  input  logic [9:0] cmd_addr,
  input  logic [7:0] cmd_wdata,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic       busy,
  output logic       nresetb,
  output logic       nspi_enb,
  output logic       spi_clk,
  output logic       spi_di,
  input  logic       spi_do
);

  localparam int unsigned RW = $clog2(RST_CYCLES + 1);
  localparam logic [RW-1:0] RLAST = RW'(RST_CYCLES - 1);
  localparam logic [7:0] DLAST = 8'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    RST_HOLD, RST_WAIT, IDLE, SETUP, SHIFT, HOLD, GAP
  } state_t;

  state_t        state_q;
  logic [RW-1:0] rcnt_q;
  logic [7:0]    div_q;
  logic [4:0]    bit_q;
  logic          phase_q;
  logic [23:0]   frame_q;
  logic [7:0]    rx_q;
  logic          wr_q;
  logic          pend_q;
  logic          cmd_ready_q;
  logic          rsp_valid_q;
  logic [7:0]    rsp_rdata_q;
  logic          busy_q;
  logic          nresetb_q;
  logic          nspi_enb_q;
  logic          spi_clk_q;
  logic          spi_di_q;

  assign cmd_ready = cmd_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign busy      = busy_q;
  assign nresetb   = nresetb_q;
  assign nspi_enb  = nspi_enb_q;
  assign spi_clk   = spi_clk_q;
  assign spi_di    = spi_di_q;

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      state_q     <= RST_HOLD;
      rcnt_q      <= '0;
      div_q       <= '0;
      bit_q       <= '0;
      phase_q     <= 1'b0;
      frame_q     <= '0;
      rx_q        <= '0;
      wr_q        <= 1'b0;
      pend_q      <= 1'b0;
      cmd_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      busy_q      <= 1'b1;
      nresetb_q   <= 1'b0;
      nspi_enb_q  <= 1'b1;
      spi_clk_q   <= 1'b0;
      spi_di_q    <= 1'b0;
    end else begin
      rsp_valid_q <= 1'b0;
      unique case (state_q)
        RST_HOLD: begin
          if (rcnt_q == RLAST) begin
            rcnt_q    <= '0;
            nresetb_q <= 1'b1;
            state_q   <= RST_WAIT;
          end else begin
            rcnt_q <= rcnt_q + 1'b1;
          end
        end
        RST_WAIT: begin
          if (rcnt_q == RLAST) begin
            rcnt_q      <= '0;
            cmd_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= IDLE;
          end else begin
            rcnt_q <= rcnt_q + 1'b1;
          end
        end
        IDLE: begin
          // reset (new or deferred) beats a command offered alongside it
          if (pend_q || reset_req) begin
            pend_q      <= 1'b0;
            rcnt_q      <= '0;
            nresetb_q   <= 1'b0;
            cmd_ready_q <= 1'b0;
            busy_q      <= 1'b1;
            state_q     <= RST_HOLD;
          end else if (cmd_valid && cmd_ready_q) begin
            frame_q     <= {cmd_write, 5'b0, cmd_addr,
                            cmd_write ? cmd_wdata : 8'h00};
            wr_q        <= cmd_write;
            spi_di_q    <= cmd_write;
            nspi_enb_q  <= 1'b0;
            cmd_ready_q <= 1'b0;
            busy_q      <= 1'b1;
            div_q       <= '0;
            state_q     <= SETUP;
          end
        end
        SETUP: begin
          if (div_q == DLAST) begin
            div_q   <= '0;
            bit_q   <= '0;
            phase_q <= 1'b0;
            state_q <= SHIFT;
          end else begin
            div_q <= div_q + 8'd1;
          end
        end
        SHIFT: begin
          if (div_q != DLAST) begin
            div_q <= div_q + 8'd1;
          end else begin
            div_q <= '0;
            if (!phase_q) begin
              // rising spi_clk: capture chip data this cycle
              phase_q   <= 1'b1;
              spi_clk_q <= 1'b1;
              rx_q      <= {rx_q[6:0], spi_do};
            end else begin
              phase_q   <= 1'b0;
              spi_clk_q <= 1'b0;
              if (bit_q == 5'd23) begin
                spi_di_q <= 1'b0;
                state_q  <= HOLD;
              end else begin
                bit_q    <= bit_q + 5'd1;
                frame_q  <= {frame_q[22:0], 1'b0};
                spi_di_q <= frame_q[22];
              end
            end
          end
        end
        HOLD: begin
          if (div_q == DLAST) begin
            div_q       <= '0;
            nspi_enb_q  <= 1'b1;
            rsp_valid_q <= 1'b1;
            rsp_rdata_q <= wr_q ? 8'h00 : rx_q;
            state_q     <= GAP;
          end else begin
            div_q <= div_q + 8'd1;
          end
        end
        GAP: begin
          if (div_q == DLAST) begin
            div_q       <= '0;
            cmd_ready_q <= !(pend_q || reset_req);
            busy_q      <= 1'b0;
            state_q     <= IDLE;
          end else begin
            div_q <= div_q + 8'd1;
          end
        end
        default: state_q <= RST_HOLD;
      endcase
      // a reset request during a frame waits for the frame to finish
      if (reset_req && (state_q inside {SETUP, SHIFT, HOLD, GAP}))
        pend_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ad936x_spi_ctrl.sv
// Bench for ad936x_spi_ctrl: timeline model of reset/frame behaviour
// compared every cycle, plus directed literal checks.
module tb_ad936x_spi_ctrl;

  localparam int D = 4;
  localparam int R = 16;
  localparam int T = 51 * D;

  logic       clock = 1'b0;
  logic       nreset = 1'b0;
  logic       reset_req = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_write = 1'b0;
  logic [9:0] cmd_addr = '0;
  logic [7:0] cmd_wdata = '0;
  logic       cmd_ready, rsp_valid, busy, nresetb;
  logic       nspi_enb, spi_clk, spi_di, spi_do;
  logic [7:0] rsp_rdata;

  always #5 clock = ~clock;

  ad936x_spi_ctrl #(.CLK_DIV(D), .RST_CYCLES(R)) dut (
    .clock(clock), .nreset(nreset), .reset_req(reset_req),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_write(cmd_write), .cmd_addr(cmd_addr),
    .cmd_wdata(cmd_wdata), .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata), .busy(busy), .nresetb(nresetb),
    .nspi_enb(nspi_enb), .spi_clk(spi_clk), .spi_di(spi_di),
    .spi_do(spi_do)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // chip model: shifts out chip_byte on rising edges 17..24
  int         rises = 0;
  logic [23:0] cap = '0;
  logic [7:0] chip_byte = 8'h00;

  function automatic logic do_bit(int r, logic [7:0] b);
    if (r >= 16 && r < 24) return b[3'(23 - r)];
    return 1'b0;
  endfunction

  assign spi_do = do_bit(rises, chip_byte);

  initial forever begin
    @(negedge nspi_enb or posedge spi_clk);
    if (spi_clk) begin
      cap = {cap[22:0], spi_di};
      rises++;
    end else begin
      cap = '0;
      rises = 0;
    end
  end

  // model: mode 0 = reset sequence, 1 = idle, 2 = transaction
  int          m_mode = 0;
  int          m_age = 0;
  logic        m_pend = 1'b0;
  logic        m_wr = 1'b0;
  logic [23:0] m_frame = '0;
  logic [7:0]  m_rdata = '0;

  task automatic m_step();
    if (!nreset) begin
      m_mode = 0; m_age = 0; m_pend = 1'b0; m_rdata = '0;
      return;
    end
    case (m_mode)
      0: begin
        m_age++;
        if (m_age == 2 * R) begin m_mode = 1; m_age = 0; end
      end
      1: begin
        if (m_pend || reset_req) begin
          m_mode = 0; m_age = 0; m_pend = 1'b0;
        end else if (cmd_valid) begin
          m_mode = 2; m_age = 0; m_wr = cmd_write;
          m_frame = {cmd_write, 5'd0, cmd_addr,
                     cmd_write ? cmd_wdata : 8'h00};
        end
      end
      default: begin
        if (reset_req) m_pend = 1'b1;
        m_age++;
        if (m_age == 50 * D) m_rdata = m_wr ? 8'h00 : chip_byte;
        if (m_age == T) begin m_mode = 1; m_age = 0; end
      end
    endcase
  endtask

  initial forever begin
    @(posedge clock or negedge nreset);
    m_step();
  end

  int n_rv = 0;
  int hi_run = 0;
  int last_gap = 0;

  initial forever begin
    int a;
    logic tx, e_clk, e_di;
    @(negedge clock);
    a = m_age;
    tx = (m_mode == 2);
    e_clk = tx && a >= D && a < 49 * D && (((a - D) / D) % 2 == 1);
    if (!tx) e_di = 1'b0;
    else if (a < D) e_di = m_frame[23];
    else if (a < 49 * D) e_di = m_frame[5'(23 - (a - D) / (2 * D))];
    else e_di = 1'b0;
    chk("cmd_ready", cmd_ready, (m_mode == 1) && !m_pend);
    chk("busy", busy, m_mode != 1);
    chk("nresetb", nresetb, !(m_mode == 0 && m_age < R));
    chk("nspi_enb", nspi_enb, !(tx && a < 50 * D));
    chk("spi_clk", spi_clk, e_clk);
    chk("spi_di", spi_di, e_di);
    chk("rsp_valid", rsp_valid, tx && a == 50 * D);
    chk("rsp_rdata", rsp_rdata, m_rdata);
    if (rsp_valid) n_rv++;
    if (nspi_enb) hi_run++;
    else begin
      if (hi_run > 0) last_gap = hi_run;
      hi_run = 0;
    end
  end

  task automatic issue(logic w, logic [9:0] ad, logic [7:0] wd);
    @(posedge clock); #2;
    cmd_write = w; cmd_addr = ad; cmd_wdata = wd; cmd_valid = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clock);
      if (cmd_ready) break;
    end
    @(posedge clock); #2;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clock);
      if (cmd_ready) break;
      n++;
    end
  endtask

  task automatic wait_rv(output int n);
    n = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clock);
      if (rsp_valid) break;
      n++;
    end
  endtask

  task automatic rst_seq(string tag);
    int n;
    n = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      if (!nresetb) n++;
      else break;
    end
    chk({tag, "_nresetb_low"}, n, R);
    n = 1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      if (!cmd_ready) n++;
      else break;
    end
    chk({tag, "_wait_len"}, n, R);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n, m, rv0;
    // power-up
    repeat (3) @(posedge clock);
    #2 nreset = 1'b1;
    rst_seq("pwrup");

    // write 0x3FF <= 0xA5
    chip_byte = 8'h3C;
    rv0 = n_rv;
    issue(1'b1, 10'h3FF, 8'hA5);
    wait_ready(n);
    chk("wr_latency", n, 204);
    chk("wr_frame", cap, 24'h83FFA5);
    chk("wr_rises", rises, 24);
    chk("wr_rdata", rsp_rdata, 8'h00);
    chk("wr_rv_count", n_rv - rv0, 1);

    // read 0x037, chip returns 0x5C
    chip_byte = 8'h5C;
    issue(1'b0, 10'h037, 8'hFF);
    wait_rv(n);
    chk("rd_rv_at", n, 200);
    chk("rd_rdata", rsp_rdata, 8'h5C);
    chk("rd_frame", cap, 24'h003700);
    wait_ready(n);
    chk("rd_tail", n, D - 1);

    // back-to-back with cmd_valid held
    chip_byte = 8'hC3;
    @(posedge clock); #2;
    cmd_write = 1'b1; cmd_addr = 10'h010; cmd_wdata = 8'h11;
    cmd_valid = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clock);
      if (cmd_ready) break;
    end
    @(posedge clock); #2;
    cmd_write = 1'b0; cmd_addr = 10'h155; cmd_wdata = 8'h00;
    wait_ready(n);
    chk("b2b_latency", n, 204);
    @(negedge clock); #1;
    cmd_valid = 1'b0;
    chk("b2b_accept_ready", cmd_ready, 1'b0);
    chk("b2b_accept_cs", nspi_enb, 1'b0);
    chk("b2b_gap", last_gap, D + 1);
    wait_rv(n);
    chk("b2b_rdata", rsp_rdata, 8'hC3);
    chk("b2b_frame", cap, 24'h015500);
    wait_ready(n);

    // reset_req with cmd_valid in IDLE
    @(posedge clock); #2;
    cmd_write = 1'b1; cmd_addr = 10'h001; cmd_wdata = 8'h77;
    cmd_valid = 1'b1; reset_req = 1'b1;
    @(posedge clock); #2;
    cmd_valid = 1'b0; reset_req = 1'b0;
    @(negedge clock);
    chk("coll_nresetb", nresetb, 1'b0);
    chk("coll_ready", cmd_ready, 1'b0);
    chk("coll_cs", nspi_enb, 1'b1);
    wait_ready(n);
    chk("coll_rst_len", n, 2 * R - 1);

    // reset_req mid-frame
    rv0 = n_rv;
    issue(1'b1, 10'h2AB, 8'h3C);
    repeat (50) @(posedge clock);
    #2 reset_req = 1'b1;
    @(posedge clock); #2 reset_req = 1'b0;
    wait_rv(n);
    chk("mid_rv_at", n, 149);
    chk("mid_frame", cap, 24'h82AB3C);
    m = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      m++;
      if (!nresetb) break;
    end
    chk("mid_rst_start", m, D + 1);
    wait_ready(n);
    chk("mid_rst_len", n, 2 * R - 1);
    chk("mid_rv_count", n_rv - rv0, 1);

    // async reset at bit 10
    chip_byte = 8'h99;
    rv0 = n_rv;
    issue(1'b0, 10'h100, 8'h00);
    for (int i = 0; i < 400; i++) begin
      @(negedge clock);
      if (rises >= 10) break;
    end
    #1 nreset = 1'b0;
    #1;
    chk("arst_rises", rises, 10);
    chk("arst_cs", nspi_enb, 1'b1);
    chk("arst_clk", spi_clk, 1'b0);
    chk("arst_nresetb", nresetb, 1'b0);
    chk("arst_rdata", rsp_rdata, 8'h00);
    repeat (3) @(posedge clock);
    #2 nreset = 1'b1;
    rst_seq("arst");
    chk("arst_rv_count", n_rv - rv0, 0);

    repeat (4) @(posedge clock);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ad936x_spi_ctrl.md
AD936X_SPI_CTRL -- requirements
Module: ad936x_spi_ctrl

Interface
REQ-001 The block SHALL have one clock, `clock`, and an asynchronous, active-low reset, `nreset`.
REQ-002 Parameter: CLK_DIV, default 4, spi_clk half-period in clock cycles (legal range 2..255).
REQ-003 Parameter: RST_CYCLES, default 1024, chip reset pulse length and post-reset wait, each in clock cycles.
REQ-004 Port: clock, input, 1, system clock.
REQ-005 Port: nreset, input, 1, asynchronous active-low reset.
REQ-006 Port: reset_req, input, 1, single-cycle request to rerun the chip reset sequence.
REQ-007 Port: cmd_valid, input, 1, command offered.
REQ-008 Port: cmd_ready, output, 1, block can accept a command.
REQ-009 Port: cmd_write, input, 1, 1 = write, 0 = read.
REQ-010 Port: cmd_addr, input, 10, AD936x register address.
REQ-011 Port: cmd_wdata, input, 8, write data.
REQ-012 Port: rsp_valid, output, 1, one-cycle completion pulse.
REQ-013 Port: rsp_rdata, output, 8, read data; 0x00 for writes.
REQ-014 Port: busy, output, 1, high in any state other than IDLE.
REQ-015 Port: nresetb, output, 1, AD936x reset, active low.
REQ-016 Port: nspi_enb, output, 1, SPI chip select, active low.
REQ-017 Port: spi_clk, output, 1, SPI clock, idle low.
REQ-018 Port: spi_di, output, 1, SPI data to chip.
REQ-019 Port: spi_do, input, 1, SPI data from chip.

Function
REQ-020 The state machine SHALL have the states RST_HOLD, RST_WAIT, IDLE, SETUP, SHIFT, HOLD and GAP.
REQ-021 RST_HOLD SHALL drive nresetb=0 for RST_CYCLES cycles and then go to RST_WAIT.
REQ-022 RST_WAIT SHALL drive nresetb=1 for RST_CYCLES cycles and then go to IDLE.
REQ-023 cmd_ready SHALL be 1 only in IDLE; a command is accepted when cmd_valid=1 and cmd_ready=1 at a rising clock edge.
REQ-024 On acceptance, the block SHALL latch a 24-bit frame: bit23=cmd_write, bits22:20=000 (single byte), bits19:18=00, bits17:8=cmd_addr, bits7:0=cmd_wdata for a write or 0x00 for a read.
REQ-025 SETUP SHALL last CLK_DIV cycles, with nspi_enb=0, spi_clk=0 and spi_di=frame bit23.
REQ-026 SHIFT SHALL clock 24 bits MSB first; each bit has a low phase of CLK_DIV cycles followed by a high phase of CLK_DIV cycles.
REQ-027 In SHIFT, spi_di SHALL change only at the start of a low phase, and spi_do SHALL be sampled in the cycle spi_clk goes high.
REQ-028 For a read, bits 7:0 of the data SHALL be assembled from the last 8 spi_do samples, MSB first.
REQ-029 After the 24th high phase, HOLD SHALL last CLK_DIV cycles with spi_clk=0 and nspi_enb=0.
REQ-030 On the HOLD-to-GAP transition, the block SHALL set nspi_enb=1, pulse rsp_valid for 1 cycle, and update rsp_rdata in the same cycle.
REQ-031 GAP SHALL last CLK_DIV cycles and then go to IDLE.
REQ-032 Total transaction time, from acceptance to the first cycle cmd_ready=1 again, SHALL be 51*CLK_DIV cycles (204 at the default CLK_DIV).
REQ-033 rsp_rdata SHALL hold its value until the next rsp_valid.
REQ-034 Outside SETUP/SHIFT/HOLD, spi_di and spi_clk SHALL both be 0.
REQ-035 If reset_req=1 in IDLE, the block SHALL go to RST_HOLD; if cmd_valid is also 1 in that cycle, reset_req wins and the command is not accepted.
REQ-036 If reset_req=1 in any other state, the request SHALL be latched and serviced on the next entry to IDLE, before any command is accepted.
REQ-037 A pending reset SHALL never abort an SPI frame.
REQ-038 A reset_req arriving during RST_HOLD or RST_WAIT SHALL be ignored.
REQ-039 The bit counter SHALL count 0..23 with no wrap, and the divider counter SHALL count 0..CLK_DIV-1.
REQ-040 All outputs SHALL be registered.

Reset
REQ-041 While nreset=0, the block SHALL hold: state=RST_HOLD, nresetb=0, nspi_enb=1, spi_clk=0, spi_di=0, cmd_ready=0, busy=1, rsp_valid=0, rsp_rdata=0x00, pending reset cleared, all counters 0.
REQ-042 When nreset is asserted mid-frame, nspi_enb SHALL go to 1 immediately (asynchronously), with no rsp_valid pulse.
REQ-043 After nreset is released, the full RST_HOLD+RST_WAIT sequence SHALL run before IDLE.

Verification
REQ-044 Power-up: release nreset with RST_CYCLES=16 -> nresetb low for 16 cycles, then high; cmd_ready rises 16 cycles later; no SPI activity.
REQ-045 Write: addr=0x3FF, wdata=0xA5, CLK_DIV=4 -> spi_di serial 0x83FFA5 over 24 rising spi_clk edges; rsp_valid pulse with rsp_rdata=0x00; cmd_ready 204 cycles after acceptance.
REQ-046 Read: addr=0x037, model returns 0x5C on spi_do -> frame 0x003700; rsp_rdata=0x5C on the rsp_valid cycle.
REQ-047 Back-to-back: cmd_valid held high for 2 commands -> second accepted exactly on the first cycle of the next IDLE; nspi_enb high for at least CLK_DIV cycles between frames.
REQ-048 Collisions: reset_req together with cmd_valid in IDLE -> no acceptance, and nresetb low next cycle; reset_req mid-frame -> frame completes with rsp_valid, then RST_HOLD starts.
REQ-049 Async reset at bit 10 of a frame -> nspi_enb=1 and spi_clk=0 the same cycle, no rsp_valid, and the full reset sequence reruns.
